// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: forwarding-select codes, hazard FSM states and
// the default register-address width.
package riscv_pipe_pkg;

   localparam int unsigned REG_AW_DEF = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } hz_state_e;

   // A producer can only forward a real write to a non-x0 register it matches.
   function automatic logic fwd_hit(input logic wr, input logic [REG_AW_DEF-1:0] rd,
                                    input logic [REG_AW_DEF-1:0] rs);
      return wr && (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Forwarding select for one EX-stage source operand; the MEM producer beats WB.
module hazard_fwd_mux_sel
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   output logic [1:0]        fwd_sel
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
   assign wb_hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs);

   always_comb begin
      fwd_sel = FWD_RF;
      if (mem_hit) begin
         fwd_sel = FWD_MEM;
      end else if (wb_hit) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline with multi-cycle memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned REG_AW      = REG_AW_DEF,
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic              mem_access,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   input  logic              pc_src_e,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic              mem_stall,
   output logic              busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       perf_lu_stalls,
   output logic [31:0]       perf_flushes,
   output logic [31:0]       perf_mem_stalls
`endif
);

   localparam bit FREEZE_EN = (MEM_LATENCY > 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = FREEZE_EN ? CNT_W'(MEM_LATENCY - 2) : '0;

   // Operand forwarding
   hazard_fwd_mux_sel #(
      .REG_AW (REG_AW)
   ) u_fwd_a (
      .ex_rs        (ex_rs1),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .fwd_sel      (fwd_a)
   );

   hazard_fwd_mux_sel #(
      .REG_AW (REG_AW)
   ) u_fwd_b (
      .ex_rs        (ex_rs2),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .fwd_sel      (fwd_b)
   );

   // Memory-latency freeze FSM
   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (FREEZE_EN && mem_access) begin
               mem_stall = 1'b1;
               cnt_d     = CNT_LOAD;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            // Counter at zero is the completing cycle: pipeline released, FSM leaves WAIT.
            if (cnt_q != '0) begin
               mem_stall = 1'b1;
               cnt_d     = cnt_q - CNT_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The release cycle already counts as idle, so busy only covers the frozen WAIT cycles.
   assign busy = (state_q == WAIT) && (cnt_q != '0);

   // Load-use and control hazards
   logic lw_stall;

   assign lw_stall = ex_is_load && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      // A frozen pipeline keeps its contents; hazards are re-evaluated after release.
      if (!mem_stall) begin
         stall_f = lw_stall && !pc_src_e;
         stall_d = lw_stall && !pc_src_e;
         flush_d = pc_src_e;
         flush_e = lw_stall || pc_src_e;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_lu_q;
   logic [31:0] perf_fl_q;
   logic [31:0] perf_ms_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_lu_q <= '0;
         perf_fl_q <= '0;
         perf_ms_q <= '0;
      end else begin
         if (stall_d && (perf_lu_q != '1)) begin
            perf_lu_q <= perf_lu_q + 32'd1;
         end
         if (flush_d && (perf_fl_q != '1)) begin
            perf_fl_q <= perf_fl_q + 32'd1;
         end
         if (mem_stall && (perf_ms_q != '1)) begin
            perf_ms_q <= perf_ms_q + 32'd1;
         end
      end
   end

   assign perf_lu_stalls  = perf_lu_q;
   assign perf_flushes    = perf_fl_q;
   assign perf_mem_stalls = perf_ms_q;
`endif

endmodule
